// File: rtl/idct_transpose_buf_if.sv
// Handshake bundle for idct_transpose_buf.
//
// Row side  : in_valid / in_ready / in_row  (row vector, index = column 0..7)
// Column side: out_valid / out_ready / out_col / out_idx / out_last
//              (column vector, index = row 0..7)
//
// Handshake rule, both sides: a transfer happens on a rising clock edge where
// valid and ready are both 1. A producer holding valid=1 keeps its payload
// stable until that transfer. Ready never depends combinationally on valid
// of the same side.
//
// Modports:
//   slave  - the transpose buffer itself (consumes rows, produces columns)
//   master - the surrounding logic (produces rows, consumes columns)
interface idct_transpose_buf_if #(
    parameter int DATA_W = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [7:0][DATA_W-1:0] in_row;
    logic                   out_valid;
    logic                   out_ready;
    logic [7:0][DATA_W-1:0] out_col;
    logic [2:0]             out_idx;
    logic                   out_last;

    modport slave (
        input  in_valid,
        input  in_row,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_col,
        output out_idx,
        output out_last
    );

    modport master (
        output in_valid,
        output in_row,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_col,
        input  out_idx,
        input  out_last
    );
endinterface

// File: rtl/idct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer between the row pass and the column pass of
// the 2-D integer IDCT. Rows are written into one bank while the other bank
// is read out column by column, giving one vector per cycle sustained.
//
// Ports:
//   clk  - single clock, all state updates on the rising edge
//   rst  - asynchronous, active-high reset; discards any stored block
//   bus  - idct_transpose_buf_if.slave
//          in_valid/in_ready/in_row    : one 8-sample row per transfer
//          out_valid/out_ready/out_col : one 8-sample column per transfer
//          out_idx                     : column index of out_col in the block
//          out_last                    : out_col is column 7
//
// The read side is purely combinational from the bank registers, so a column
// is visible the cycle after the block's 8th row is written and it holds
// stable for as long as out_ready stays low.
module idct_transpose_buf #(
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    idct_transpose_buf_if.slave  bus
);

    logic [DATA_W-1:0] bank [2][8][8];
    logic [1:0]        full;
    logic              wr_bank;
    logic [2:0]        wr_row;
    logic              rd_bank;
    logic [2:0]        rd_col;

    logic              wr_fire;
    logic              rd_fire;

    // Write needs an empty bank, read needs a full one, so the two sides can
    // never address the same bank in the same cycle.
    assign wr_fire = bus.in_valid && !full[wr_bank];
    assign rd_fire = bus.out_ready && full[rd_bank];

    assign bus.in_ready  = !full[wr_bank];
    assign bus.out_valid = full[rd_bank];
    assign bus.out_idx   = rd_col;
    assign bus.out_last  = full[rd_bank] && (rd_col == 3'd7);

    always_comb begin
        bus.out_col = '0;
        for (int r = 0; r < 8; r++) begin
            bus.out_col[r] = bank[rd_bank][r][rd_col];
        end
    end

    // Sample storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 8; r++) begin
                    for (int c = 0; c < 8; c++) begin
                        bank[b][r][c] <= '0;
                    end
                end
            end
        end else if (wr_fire) begin
            for (int c = 0; c < 8; c++) begin
                bank[wr_bank][wr_row][c] <= bus.in_row[c];
            end
        end
    end

    // Bank pointers and full flags. The 3-bit row/column counters wrap from 7
    // to 0 on their own; the bank toggles at that same wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= '0;
            wr_bank <= 1'b0;
            wr_row  <= '0;
            rd_bank <= 1'b0;
            rd_col  <= '0;
        end else begin
            if (wr_fire) begin
                wr_row <= wr_row + 3'd1;
                if (wr_row == 3'd7) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            if (rd_fire) begin
                rd_col <= rd_col + 3'd1;
                if (rd_col == 3'd7) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end
            end
        end
    end

endmodule
